// File: rtl/bp_pkg.sv
// Shared types for the branch predictor: counter encoding, BTB entry layout,
// training opcodes and saturating counter helpers.
package bp_pkg;

    localparam int unsigned BP_XLEN        = 32;
    localparam int unsigned BP_BTB_ENTRIES = 16;
    localparam int unsigned BP_IDX_W       = $clog2(BP_BTB_ENTRIES);
    localparam int unsigned BP_TAG_W       = BP_XLEN - BP_IDX_W - 2;

    typedef enum logic [1:0] {
        CTR_SNT = 2'b00,
        CTR_WNT = 2'b01,
        CTR_WT  = 2'b10,
        CTR_ST  = 2'b11
    } bp_ctr_t;

    typedef enum logic [1:0] {
        TRAIN_TAKEN     = 2'd0,
        TRAIN_NOT_TAKEN = 2'd1,
        TRAIN_INVAL     = 2'd2
    } train_op_e;

    typedef struct packed {
        logic                valid;
        logic [BP_TAG_W-1:0] tag;
        logic [BP_XLEN-1:0]  target;
        bp_ctr_t             ctr;
    } btb_entry_t;

    function automatic bp_ctr_t sat_inc(input bp_ctr_t c);
        return (c == CTR_ST) ? CTR_ST : bp_ctr_t'(2'(c) + 2'd1);
    endfunction

    function automatic bp_ctr_t sat_dec(input bp_ctr_t c);
        return (c == CTR_SNT) ? CTR_SNT : bp_ctr_t'(2'(c) - 2'd1);
    endfunction

endpackage

// File: rtl/btb_array.sv
// Direct-mapped BTB storage.
//   rd_pc / rd_hit_c / rd_ctr_c / rd_target_c : async lookup port
//   wr_en / wr_op / wr_pc / wr_target         : training port, applied at the edge;
//                                               hit for the training PC is resolved here
//   inval_all                                 : clears every valid bit, beats training
module btb_array
    import bp_pkg::*;
#(
    parameter int unsigned XLEN        = BP_XLEN,
    parameter int unsigned BTB_ENTRIES = BP_BTB_ENTRIES,
    parameter int unsigned IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] rd_pc,
    output logic            rd_hit_c,
    output bp_ctr_t         rd_ctr_c,
    output logic [XLEN-1:0] rd_target_c,
    input  logic            wr_en,
    input  train_op_e       wr_op,
    input  logic [XLEN-1:0] wr_pc,
    input  logic [XLEN-1:0] wr_target,
    input  logic            inval_all
);

    btb_entry_t       entries_q [BTB_ENTRIES];
    btb_entry_t       entries_d [BTB_ENTRIES];
    logic [IDX_W-1:0] rd_idx;
    logic [IDX_W-1:0] wr_idx;
    btb_entry_t       rd_e;
    btb_entry_t       wr_e;
    logic             wr_hit;

    function automatic logic [BP_TAG_W-1:0] tag_of(input logic [XLEN-1:0] pc);
        return BP_TAG_W'(pc >> (IDX_W + 2));
    endfunction

    // Lookup: sees the pre-update entry, no write bypass.
    always_comb begin
        rd_idx      = rd_pc[IDX_W+1:2];
        rd_e        = entries_q[rd_idx];
        rd_hit_c    = rd_e.valid && (rd_e.tag == tag_of(rd_pc));
        rd_ctr_c    = rd_e.ctr;
        rd_target_c = XLEN'(rd_e.target);
    end

    // Next-state of the array: bulk invalidate first, otherwise one training write.
    always_comb begin
        entries_d = entries_q;
        wr_idx    = wr_pc[IDX_W+1:2];
        wr_e      = entries_q[wr_idx];
        wr_hit    = wr_e.valid && (wr_e.tag == tag_of(wr_pc));
        if (inval_all) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                entries_d[i].valid = 1'b0;
            end
        end else if (wr_en) begin
            case (wr_op)
                TRAIN_TAKEN: begin
                    entries_d[wr_idx].valid  = 1'b1;
                    entries_d[wr_idx].tag    = tag_of(wr_pc);
                    entries_d[wr_idx].target = BP_XLEN'(wr_target);
                    entries_d[wr_idx].ctr    = wr_hit ? sat_inc(wr_e.ctr) : CTR_WT;
                end
                TRAIN_NOT_TAKEN: begin
                    if (wr_hit) entries_d[wr_idx].ctr = sat_dec(wr_e.ctr);
                end
                TRAIN_INVAL: begin
                    if (wr_hit) entries_d[wr_idx].valid = 1'b0;
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(BTB_ENTRIES); i++) begin
                entries_q[i] <= '{valid: 1'b0, tag: '0, target: '0, ctr: CTR_WNT};
            end
        end else begin
            entries_q <= entries_d;
        end
    end

endmodule

// File: rtl/branch_pred_ctrl.sv
// Branch predictor and mispredict-recovery controller.
//   IF side : if_pc -> pred_taken / pred_target (combinational BTB lookup)
//   EX side : ex_* resolved outcome vs. piped prediction -> redirect, redirect_pc,
//             flush_if_id, flush_id_ex (same cycle); trains the BTB at the edge
//   btb_flush : invalidates the whole BTB (fence.i)
//   Optional BRANCH_PRED_STATS_EN adds stat_branches / stat_mispred counters.
module branch_pred_ctrl
    import bp_pkg::*;
#(
    parameter int unsigned XLEN        = BP_XLEN,
    parameter int unsigned BTB_ENTRIES = BP_BTB_ENTRIES,
    parameter int unsigned IDX_W       = $clog2(BTB_ENTRIES)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [XLEN-1:0] if_pc,
    output logic            pred_taken,
    output logic [XLEN-1:0] pred_target,
    input  logic            ex_valid,
    input  logic            ex_stall,
    input  logic [XLEN-1:0] ex_pc,
    input  logic            ex_is_branch,
    input  logic            ex_taken,
    input  logic [XLEN-1:0] ex_actual_pc,
    input  logic            ex_pred_taken,
    input  logic [XLEN-1:0] ex_pred_target,
    input  logic            btb_flush,
    output logic            redirect,
    output logic [XLEN-1:0] redirect_pc,
    output logic            flush_if_id,
    output logic            flush_id_ex
`ifdef BRANCH_PRED_STATS_EN
    ,
    output logic [31:0]     stat_branches,
    output logic [31:0]     stat_mispred
`endif
);

    logic            lk_hit;
    bp_ctr_t         lk_ctr;
    logic [XLEN-1:0] lk_target;
    logic            act;
    logic            mispred;
    train_op_e       train_op;

    btb_array #(
        .XLEN        (XLEN),
        .BTB_ENTRIES (BTB_ENTRIES),
        .IDX_W       (IDX_W)
    ) u_btb (
        .clk         (clk),
        .rst_n       (rst_n),
        .rd_pc       (if_pc),
        .rd_hit_c    (lk_hit),
        .rd_ctr_c    (lk_ctr),
        .rd_target_c (lk_target),
        .wr_en       (act),
        .wr_op       (train_op),
        .wr_pc       (ex_pc),
        .wr_target   (ex_actual_pc),
        .inval_all   (btb_flush)
    );

    // Fetch prediction.
    always_comb begin
        pred_taken  = lk_hit && ((lk_ctr == CTR_WT) || (lk_ctr == CTR_ST));
        pred_target = pred_taken ? lk_target : (if_pc + XLEN'(4));
    end

    // Resolve; rst_n gates act so a pending redirect drops the moment reset asserts.
    always_comb begin
        act     = rst_n && ex_valid && !ex_stall;
        mispred = act && ((ex_is_branch && (ex_taken != ex_pred_taken))
                       || (ex_is_branch && ex_taken && (ex_actual_pc != ex_pred_target))
                       || (!ex_is_branch && ex_pred_taken));
        redirect    = mispred;
        flush_if_id = mispred;
        flush_id_ex = mispred;
        redirect_pc = ex_is_branch ? ex_actual_pc : (ex_pc + XLEN'(4));
        train_op    = TRAIN_INVAL;
        if (ex_is_branch) train_op = ex_taken ? TRAIN_TAKEN : TRAIN_NOT_TAKEN;
    end

`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] stat_branches_q, stat_branches_d;
    logic [31:0] stat_mispred_q,  stat_mispred_d;

    // Event counters; wrap naturally, untouched by btb_flush.
    always_comb begin
        stat_branches_d = stat_branches_q;
        stat_mispred_d  = stat_mispred_q;
        if (act && ex_is_branch) stat_branches_d = stat_branches_q + 32'd1;
        if (mispred)             stat_mispred_d  = stat_mispred_q + 32'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stat_branches_q <= '0;
            stat_mispred_q  <= '0;
        end else begin
            stat_branches_q <= stat_branches_d;
            stat_mispred_q  <= stat_mispred_d;
        end
    end

    assign stat_branches = stat_branches_q;
    assign stat_mispred  = stat_mispred_q;
`endif

endmodule

// File: tb/tb_branch_pred_ctrl.sv
`timescale 1ns/1ps
module tb_branch_pred_ctrl;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [31:0] if_pc = '0;
    logic        pred_taken;
    logic [31:0] pred_target;
    logic        ex_valid = 1'b0;
    logic        ex_stall = 1'b0;
    logic [31:0] ex_pc = '0;
    logic        ex_is_branch = 1'b0;
    logic        ex_taken = 1'b0;
    logic [31:0] ex_actual_pc = '0;
    logic        ex_pred_taken = 1'b0;
    logic [31:0] ex_pred_target = '0;
    logic        btb_flush = 1'b0;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        flush_if_id;
    logic        flush_id_ex;
`ifdef BRANCH_PRED_STATS_EN
    logic [31:0] stat_branches;
    logic [31:0] stat_mispred;
`endif

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    branch_pred_ctrl dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .if_pc          (if_pc),
        .pred_taken     (pred_taken),
        .pred_target    (pred_target),
        .ex_valid       (ex_valid),
        .ex_stall       (ex_stall),
        .ex_pc          (ex_pc),
        .ex_is_branch   (ex_is_branch),
        .ex_taken       (ex_taken),
        .ex_actual_pc   (ex_actual_pc),
        .ex_pred_taken  (ex_pred_taken),
        .ex_pred_target (ex_pred_target),
        .btb_flush      (btb_flush),
        .redirect       (redirect),
        .redirect_pc    (redirect_pc),
        .flush_if_id    (flush_if_id),
        .flush_id_ex    (flush_id_ex)
`ifdef BRANCH_PRED_STATS_EN
        ,
        .stat_branches  (stat_branches),
        .stat_mispred   (stat_mispred)
`endif
    );

    // Reference model: 16-entry table, counters as plain integers 0..3.
    bit          m_valid [16];
    logic [31:0] m_tag   [16];
    logic [31:0] m_tgt   [16];
    int          m_ctr   [16];
    int          m_nbr;
    int          m_nmis;

    function automatic int idx_of(input logic [31:0] pc);
        return int'((pc / 4) % 16);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] pc);
        return pc / 64;
    endfunction

    function automatic bit m_hit(input logic [31:0] pc);
        return m_valid[idx_of(pc)] && (m_tag[idx_of(pc)] == tag_of(pc));
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 16; i++) begin
            m_valid[i] = 1'b0; m_tag[i] = '0; m_tgt[i] = '0; m_ctr[i] = 1;
        end
        m_nbr = 0; m_nmis = 0;
    endtask

    task automatic model_pred(input logic [31:0] pc, output bit t, output logic [31:0] tg);
        t  = m_hit(pc) && (m_ctr[idx_of(pc)] >= 2);
        tg = t ? m_tgt[idx_of(pc)] : pc + 32'd4;
    endtask

    task automatic model_resolve(output bit mis, output logic [31:0] rpc);
        bit a;
        a   = rst_n && ex_valid && !ex_stall;
        mis = a && ((ex_is_branch && ex_taken != ex_pred_taken)
                 || (ex_is_branch && ex_taken && ex_actual_pc != ex_pred_target)
                 || (!ex_is_branch && ex_pred_taken));
        rpc = ex_is_branch ? ex_actual_pc : ex_pc + 32'd4;
    endtask

    task automatic model_update();
        bit a, h, mis;
        int i;
        logic [31:0] rpc;
        a = rst_n && ex_valid && !ex_stall;
        model_resolve(mis, rpc);
        if (a && ex_is_branch) m_nbr++;
        if (mis) m_nmis++;
        i = idx_of(ex_pc);
        h = m_hit(ex_pc);
        if (btb_flush) begin
            for (int k = 0; k < 16; k++) m_valid[k] = 1'b0;
        end else if (a) begin
            if (ex_is_branch && ex_taken) begin
                m_valid[i] = 1'b1; m_tag[i] = tag_of(ex_pc); m_tgt[i] = ex_actual_pc;
                m_ctr[i] = h ? ((m_ctr[i] < 3) ? m_ctr[i] + 1 : 3) : 2;
            end else if (ex_is_branch) begin
                if (h && m_ctr[i] > 0) m_ctr[i] = m_ctr[i] - 1;
            end else if (h) begin
                m_valid[i] = 1'b0;
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic chk_model(input string p);
        bit et, em;
        logic [31:0] etg, erpc;
        model_pred(if_pc, et, etg);
        model_resolve(em, erpc);
        chk({p, ".pred_taken"},  32'(pred_taken),  32'(et));
        chk({p, ".pred_target"}, pred_target,      etg);
        chk({p, ".redirect"},    32'(redirect),    32'(em));
        chk({p, ".flush_if_id"}, 32'(flush_if_id), 32'(em));
        chk({p, ".flush_id_ex"}, 32'(flush_id_ex), 32'(em));
        chk({p, ".redirect_pc"}, redirect_pc,      erpc);
    endtask

    task automatic drive(input logic [31:0] ip, input bit v, input bit st, input logic [31:0] ep,
                         input bit br, input bit tk, input logic [31:0] ap,
                         input bit pt, input logic [31:0] pg, input bit fl);
        if_pc = ip; ex_valid = v; ex_stall = st; ex_pc = ep; ex_is_branch = br;
        ex_taken = tk; ex_actual_pc = ap; ex_pred_taken = pt; ex_pred_target = pg; btb_flush = fl;
    endtask

    task automatic idle(input logic [31:0] ip);
        drive(ip, 0, 0, 32'h0, 0, 0, 32'h0, 0, 32'h0, 0);
    endtask

    typedef struct {
        logic [31:0] ip; bit v; bit st; logic [31:0] ep; bit br; bit tk;
        logic [31:0] ap; bit pt; logic [31:0] pg; bit fl;
        bit e_pt; logic [31:0] e_tg; bit e_rd; logic [31:0] e_rpc;
    } vec_t;

    function automatic vec_t mk(input logic [31:0] ip, input bit v, input bit st, input logic [31:0] ep,
                                input bit br, input bit tk, input logic [31:0] ap, input bit pt,
                                input logic [31:0] pg, input bit fl, input bit e_pt,
                                input logic [31:0] e_tg, input bit e_rd, input logic [31:0] e_rpc);
        vec_t r;
        r.ip = ip; r.v = v; r.st = st; r.ep = ep; r.br = br; r.tk = tk; r.ap = ap;
        r.pt = pt; r.pg = pg; r.fl = fl; r.e_pt = e_pt; r.e_tg = e_tg; r.e_rd = e_rd; r.e_rpc = e_rpc;
        return r;
    endfunction

    task automatic do_reset();
        idle(32'h100);
        rst_n = 1'b0;
        model_reset();
        #7;
        chk("reset.pred_taken",  32'(pred_taken),  32'd0);
        chk("reset.pred_target", pred_target,      32'h104);
        chk("reset.redirect",    32'(redirect),    32'd0);
        chk("reset.flush_if_id", 32'(flush_if_id), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
    endtask

    vec_t vecs[$];

    initial begin
        // Directed table: cold start, hysteresis, wrong target, alias, wrap, invalid EX.
        vecs.push_back(mk(32'h100, 0,0,32'h0,  0,0,32'h0,  0,32'h0,  0, 0,32'h104, 0,32'h0));
        vecs.push_back(mk(32'h100, 1,0,32'h100,1,1,32'h80, 0,32'h104,0, 0,32'h104, 1,32'h80));
        vecs.push_back(mk(32'h100, 0,0,32'h0,  0,0,32'h0,  0,32'h0,  0, 1,32'h80,  0,32'h0));
        vecs.push_back(mk(32'h100, 1,0,32'h100,1,1,32'h80, 1,32'h80, 0, 1,32'h80,  0,32'h0));
        vecs.push_back(mk(32'h100, 1,0,32'h100,1,1,32'h80, 1,32'h80, 0, 1,32'h80,  0,32'h0));
        vecs.push_back(mk(32'h100, 1,0,32'h100,1,0,32'h104,1,32'h80, 0, 1,32'h80,  1,32'h104));
        vecs.push_back(mk(32'h100, 0,0,32'h0,  0,0,32'h0,  0,32'h0,  0, 1,32'h80,  0,32'h0));
        vecs.push_back(mk(32'h100, 1,0,32'h100,1,0,32'h104,1,32'h80, 0, 1,32'h80,  1,32'h104));
        vecs.push_back(mk(32'h100, 0,0,32'h0,  0,0,32'h0,  0,32'h0,  0, 0,32'h104, 0,32'h0));
        vecs.push_back(mk(32'h200, 1,0,32'h200,1,1,32'h340,1,32'h300,0, 0,32'h204, 1,32'h340));
        vecs.push_back(mk(32'h200, 0,0,32'h0,  0,0,32'h0,  0,32'h0,  0, 1,32'h340, 0,32'h0));
        vecs.push_back(mk(32'h400, 1,0,32'h400,1,1,32'h500,1,32'h500,0, 0,32'h404, 0,32'h0));
        vecs.push_back(mk(32'h400, 1,0,32'h400,0,0,32'h0,  1,32'h500,0, 1,32'h500, 1,32'h404));
        vecs.push_back(mk(32'h400, 0,0,32'h0,  0,0,32'h0,  0,32'h0,  0, 0,32'h404, 0,32'h0));
        vecs.push_back(mk(32'hFFFF_FFFC,0,0,32'h0,0,0,32'h0,0,32'h0, 0, 0,32'h0,   0,32'h0));
        vecs.push_back(mk(32'h100, 0,0,32'h100,1,1,32'h80, 0,32'h104,0, 0,32'h104, 0,32'h0));
        vecs.push_back(mk(32'h100, 0,0,32'h0,  0,0,32'h0,  0,32'h0,  0, 0,32'h104, 0,32'h0));

        do_reset();

        foreach (vecs[n]) begin
            string p;
            p = $sformatf("vec%0d", n);
            drive(vecs[n].ip, vecs[n].v, vecs[n].st, vecs[n].ep, vecs[n].br, vecs[n].tk,
                  vecs[n].ap, vecs[n].pt, vecs[n].pg, vecs[n].fl);
            #2;
            chk({p, ".pred_taken"},  32'(pred_taken),  32'(vecs[n].e_pt));
            chk({p, ".pred_target"}, pred_target,      vecs[n].e_tg);
            chk({p, ".redirect"},    32'(redirect),    32'(vecs[n].e_rd));
            chk({p, ".flush_id_ex"}, 32'(flush_id_ex), 32'(vecs[n].e_rd));
            if (vecs[n].e_rd) chk({p, ".redirect_pc"}, redirect_pc, vecs[n].e_rpc);
            tick();
        end

        // Random traffic against the model.
        for (int c = 0; c < 400; c++) begin
            logic [31:0] ip, ep, ap, pg;
            bit br, tk, pt;
            ip = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            ep = (32'($urandom_range(0, 3)) << 8) | (32'($urandom_range(0, 7)) << 2);
            br = ($urandom_range(0, 4) != 0);
            tk = br && $urandom_range(0, 1) == 1;
            ap = tk ? (32'($urandom_range(0, 7)) << 4) : ep + 32'd4;
            if ($urandom_range(0, 3) != 0) begin
                model_pred(ep, pt, pg);
            end else begin
                pt = $urandom_range(0, 1) == 1;
                pg = 32'($urandom_range(0, 7)) << 4;
            end
            drive(ip, $urandom_range(0, 4) != 0, $urandom_range(0, 3) == 0, ep, br, tk, ap, pt, pg,
                  $urandom_range(0, 30) == 0);
            #2;
            chk_model($sformatf("rnd%0d", c));
            tick();
        end

        // Stall: held mispredict produces nothing until the stall drops, then exactly once.
        do_reset();
        drive(32'h100, 1,0,32'h100,1,1,32'h80, 0,32'h104,0);
        tick();
        drive(32'h100, 1,1,32'h100,1,0,32'h104,1,32'h80, 0);
        for (int k = 0; k < 3; k++) begin
            #2;
            chk("stall.redirect",    32'(redirect),    32'd0);
            chk("stall.flush_if_id", 32'(flush_if_id), 32'd0);
            chk("stall.pred_taken",  32'(pred_taken),  32'd1);
            tick();
        end
        ex_stall = 1'b0;
        #2;
        chk("unstall.redirect",    32'(redirect),    32'd1);
        chk("unstall.redirect_pc", redirect_pc,      32'h104);
        chk("unstall.flush_if_id", 32'(flush_if_id), 32'd1);
        tick();
        idle(32'h100);
        #2;
        chk("post_unstall.redirect",   32'(redirect),   32'd0);
        chk("post_unstall.pred_taken", 32'(pred_taken), 32'd0);
        tick();
        drive(32'h100, 1,0,32'h100,1,1,32'h80, 0,32'h104,0);
        tick();
        idle(32'h100);
        #2;
        chk("single_dec.pred_taken",  32'(pred_taken), 32'd1);
        chk("single_dec.pred_target", pred_target,     32'h80);

        // Flush beats a simultaneous taken-branch train.
        drive(32'h100, 1,0,32'h200,1,1,32'h240,0,32'h204,1);
        tick();
        idle(32'h200);
        #1;
        chk("flush.pred_taken_200", 32'(pred_taken), 32'd0);
        chk("flush.pred_target_200", pred_target,    32'h204);
        for (int i = 0; i < 16; i++) begin
            if_pc = 32'h100 | (32'(i) << 2);
            #1;
            chk($sformatf("flush.miss%0d", i), 32'(pred_taken), 32'd0);
        end
        tick();

        // Reset asserted while a redirect is active.
        drive(32'h400, 1,0,32'h400,0,0,32'h0,1,32'h500,0);
        #2;
        chk("prerst.redirect", 32'(redirect), 32'd1);
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst.redirect",    32'(redirect),    32'd0);
        chk("midrst.flush_id_ex", 32'(flush_id_ex), 32'd0);
        idle(32'h100);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        #1;
        chk_model("after_rst");

`ifdef BRANCH_PRED_STATS_EN
        chk("stat_branches", stat_branches, 32'(m_nbr));
        chk("stat_mispred",  stat_mispred,  32'(m_nmis));
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/branch_pred_ctrl.md
Name: branch_pred_ctrl

Overview:
- Branch predictor and mispredict-recovery controller for the 5-stage pipeline.
- IF side: a direct-mapped BTB with 2-bit saturating counters supplies the next-fetch prediction.
- EX side: compares the branch unit's resolved outcome (is_branch, taken, actual next PC) against the prediction carried down the pipe, raises redirect/flush on mismatch, and trains the BTB.

Parameters:
- XLEN, 32, datapath/PC width.
- BTB_ENTRIES, 16, BTB depth; power of two, 2..256.
- IDX_W, $clog2(BTB_ENTRIES), index width (derived).

Ports:
- clk  in  1  system clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- if_pc  in  XLEN  PC being fetched.
- pred_taken  out  1  predicted taken for if_pc.
- pred_target  out  XLEN  predicted next PC (if_pc+4 when not taken).
- ex_valid  in  1  EX holds a valid instruction.
- ex_stall  in  1  EX frozen this cycle.
- ex_pc  in  XLEN  PC of EX instruction.
- ex_is_branch  in  1  branch unit op is not NOP (branch/jal/jalr).
- ex_taken  in  1  branch unit result.
- ex_actual_pc  in  XLEN  resolved next PC from the branch unit.
- ex_pred_taken  in  1  prediction piped from IF.
- ex_pred_target  in  XLEN  predicted next PC piped from IF.
- btb_flush  in  1  invalidate all BTB entries (fence.i).
- redirect  out  1  mispredict: refetch from redirect_pc.
- redirect_pc  out  XLEN  correct next PC.
- flush_if_id  out  1  squash IF/ID.
- flush_id_ex  out  1  squash ID/EX.

Behaviour:
- Clock and reset: one clock clk; reset rst_n is asynchronous, active-low.
- Reset state: all entries valid=0, tag=0, target=0, ctr=2'b01 (weakly not-taken). Outputs pred_taken=0, pred_target=if_pc+4, redirect=0, flushes=0.
- Index and tag: idx = pc[IDX_W+1:2]; tag = pc[XLEN-1:IDX_W+2].
- Lookup (combinational, 0 latency):
  - hit = valid[idx] && tag match.
  - pred_taken = hit && ctr[1].
  - pred_target = pred_taken ? target[idx] : if_pc+4. PC+4 wraps mod 2^XLEN.
- Resolve: act = ex_valid && !ex_stall. Mispredict (combinational, same cycle) when act and any of:
  - ex_is_branch and ex_taken != ex_pred_taken;
  - ex_is_branch and ex_taken and ex_actual_pc != ex_pred_target;
  - !ex_is_branch and ex_pred_taken (aliased entry).
- Redirect outputs:
  - On mispredict: redirect=flush_if_id=flush_id_ex=1, for one cycle per resolving instruction.
  - redirect_pc = ex_is_branch ? ex_actual_pc : ex_pc+4.
  - When stalled: no redirect, no training; the event is taken once when the stall drops.
- Training, at the clock edge when act:
  - taken branch: write tag, target=ex_actual_pc, valid=1. ctr = hit ? sat_inc(ctr) : 2'b10.
  - not-taken branch with hit: ctr = sat_dec(ctr).
  - not-taken branch with miss: no allocation.
  - non-branch with hit: valid=0.
- Saturation: 11 stays 11; 00 stays 00.
- Read/write same index in one cycle: the lookup sees the pre-update entry; no bypass.
- btb_flush: clears all valid bits at the edge and has priority over training in the same cycle. ctr/target are untouched.
- Reset mid-operation: immediate return to the reset state; any pending redirect is dropped.

Optional Feature:
- Macro: BRANCH_PRED_STATS_EN.
- When defined:
  - adds outputs stat_branches[31:0] (count of act && ex_is_branch) and stat_mispred[31:0] (count of mispredicts);
  - both counters wrap, reset to 0, and are not cleared by btb_flush.
- When undefined: ports and logic absent; behaviour otherwise identical.

Decomposition:
- Shared package bp_pkg:
  - typedef bp_ctr_t (2-bit) with CTR_SNT=00, CTR_WNT=01, CTR_WT=10, CTR_ST=11;
  - struct btb_entry_t {valid, tag, target, ctr};
  - functions sat_inc and sat_dec.
- One sub-module, btb_array: register array with one async read port (lookup), one write port (training), and a bulk invalidate.
- Mispredict/redirect logic stays in branch_pred_ctrl.

Test Plan:
- Cold start: if_pc=0x100 → pred_taken=0, pred_target=0x104. Resolve BEQ at 0x100 taken to 0x80 (pred 0) → redirect=1, redirect_pc=0x80, both flushes=1. Next lookup of 0x100 → pred_taken=1, target=0x80.
- Hysteresis: train 0x100 taken ×3 (ctr=11), then not-taken ×1 → still predicts taken; second not-taken → predicts not-taken, pred_target=0x104.
- Wrong target: JALR at 0x200 predicted taken to 0x300, actual 0x340 → redirect_pc=0x340; next lookup target=0x340.
- Alias/non-branch: ex_is_branch=0, ex_pred_taken=1, ex_pc=0x400 → redirect_pc=0x404; entry invalidated, next lookup of 0x400 predicts not-taken.
- Stall: mispredict held with ex_stall=1 for 3 cycles → no redirect, BTB unchanged. Stall drops → exactly one redirect cycle and one counter update.
- btb_flush asserted with a simultaneous taken-branch train → every lookup misses afterwards. Async rst_n low mid-redirect → redirect drops immediately.
